// File: rtl/uart_frame_loader.sv
// Loads an AA 55 framed stream of NPIX pixel bytes from a UART into a frame buffer; define UART_FRAME_CHECKSUM_EN for a trailing mod-256 check byte.
// Latency: rx_done to wr_en is 1 clk. No backpressure: one byte per cycle is accepted, back-to-back.
module uart_frame_loader #(
  parameter int NPIX    = 76800,
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
`ifdef UART_FRAME_CHECKSUM_EN
    , CHK = 2'd3
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              timeout_hit;
  logic              last_pix;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]        cks;
`endif

  // An rx_done in the expiry cycle wins, so the timeout only fires on a silent cycle.
  assign timeout_hit = !rx_done && (gap_cnt == GAP_W'(TIMEOUT - 1));
  assign last_pix    = (pix_cnt == ADDR_W'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      gap_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      cks        <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || rx_done) gap_cnt <= '0;
      else                          gap_cnt <= gap_cnt + GAP_W'(1);

      case (state)
        IDLE: begin
          if (rx_done && rx_data == 8'hAA) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end

        SYNC: begin
          if (rx_done) begin
            if (rx_data == 8'h55) begin
              state   <= DATA;
              pix_cnt <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              cks     <= '0;
`endif
            end else if (rx_data != 8'hAA) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end

        DATA: begin
          if (rx_done) begin
            wr_en   <= 1'b1;
            wr_addr <= pix_cnt;
            wr_data <= rx_data;
`ifdef UART_FRAME_CHECKSUM_EN
            cks     <= cks + rx_data;
`endif
            if (last_pix) begin
              pix_cnt <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              state      <= CHK;
`else
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end

`ifdef UART_FRAME_CHECKSUM_EN
        CHK: begin
          if (rx_done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= (rx_data == cks);
            frame_err  <= (rx_data != cks);
          end else if (timeout_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
`endif

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed + randomized bench for uart_frame_loader with NPIX=4, TIMEOUT=50.
module tb_uart_frame_loader;
  localparam int NPIX    = 4;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 50;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  int tests = 0;
  int fails = 0;
  int both_hi = 0;

  uart_frame_loader #(.NPIX(NPIX), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done && frame_err) both_hi++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_out(input string tag, input bit we, input int addr, input logic [7:0] dat,
                            input bit done, input bit err, input bit bsy);
    check({tag, ".wr_en"}, 32'(wr_en), 32'(we));
    if (we) begin
      check({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
      check({tag, ".wr_data"}, 32'(wr_data), 32'(dat));
    end
    check({tag, ".frame_done"}, 32'(frame_done), 32'(done));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(err));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  // Reference: after the header each pixel i lands at address i; the frame ends on the
  // last pixel (or on the check byte, which must equal the mod-256 pixel sum).
  task automatic send_frame(input string tag, input logic [7:0] px [NPIX], input int n_aa,
                            input bit bad_ck, input int max_gap);
    logic [7:0] sum;
    bit         last;
    sum = 8'h00;
    for (int k = 0; k < n_aa; k++) begin
      idle($urandom_range(0, max_gap));
      send(8'hAA);
      expect_out({tag, ".aa"}, 0, 0, 0, 0, 0, 1);
    end
    idle($urandom_range(0, max_gap));
    send(8'h55);
    expect_out({tag, ".55"}, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NPIX; i++) begin
      idle($urandom_range(0, max_gap));
      send(px[i]);
      sum  = sum + px[i];
      last = (i == NPIX - 1);
      expect_out($sformatf("%s.pix%0d", tag, i), 1, i, px[i], last && !CK, 0, !(last && !CK));
    end
    if (CK) begin
      idle($urandom_range(0, max_gap));
      send(bad_ck ? sum + 8'h01 : sum);
      expect_out({tag, ".ck"}, 0, 0, 0, !bad_ck, bad_ck, 0);
    end
    @(posedge clk);
    #1;
    expect_out({tag, ".after"}, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] px [NPIX];
    logic [7:0] g;
    int         hits;
    int         at;

    // Reset state, with a byte strobed during reset that must be ignored.
    rx_data = 8'hAA;
    rx_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.wr_addr", 32'(wr_addr), 0);
    check("reset.wr_data", 32'(wr_data), 0);
    @(negedge clk);
    rx_done = 1'b0;
    rst_n   = 1'b1;
    send(8'h55);
    expect_out("post_reset_55", 0, 0, 0, 0, 0, 0);

    // Basic frame with fixed pixels, back-to-back bytes.
    px = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame("basic", px, 1, 0, 0);

    // Header recovery: junk, then repeated AA before 55.
    send(8'h12);
    expect_out("junk12", 0, 0, 0, 0, 0, 0);
    px = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame("recover", px, 2, 0, 2);

    // Header abort.
    send(8'hAA);
    expect_out("abort.aa", 0, 0, 0, 0, 0, 1);
    send(8'h33);
    expect_out("abort.33", 0, 0, 0, 0, 0, 0);

    // Randomized frames with random junk prefixes and gaps.
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        do g = 8'($urandom); while (g == 8'hAA);
        send(g);
        expect_out($sformatf("rnd%0d.junk", f), 0, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < NPIX; i++) px[i] = 8'($urandom);
      send_frame($sformatf("rnd%0d", f), px, int'($urandom_range(1, 2)), 0, 4);
    end

    // Timeout: frame_err exactly TIMEOUT cycles after the last byte's write.
    send(8'hAA);
    send(8'h55);
    send(8'h01);
    send(8'h02);
    expect_out("to.pix1", 1, 1, 8'h02, 0, 0, 1);
    hits = 0;
    at   = -1;
    for (int n = 1; n <= TIMEOUT + 10; n++) begin
      @(posedge clk);
      #1;
      if (frame_err) begin
        hits++;
        if (at < 0) at = n;
      end
    end
    check("timeout.cycle", 32'(at), 32'(TIMEOUT));
    check("timeout.pulses", 32'(hits), 1);
    check("timeout.busy", 32'(busy), 0);
    for (int i = 0; i < NPIX; i++) px[i] = 8'($urandom);
    send_frame("after_to", px, 1, 0, 1);

    // A byte landing on the expiry cycle is taken and restarts the gap.
    send(8'hAA);
    send(8'h55);
    send(8'h07);
    idle(TIMEOUT - 1);
    send(8'h08);
    expect_out("edge.pix1", 1, 1, 8'h08, 0, 0, 1);
    idle(TIMEOUT - 1);
    @(posedge clk);
    #1;
    expect_out("edge.expire", 0, 0, 0, 0, 1, 0);

    // Mid-frame reset abandons the frame silently.
    send(8'hAA);
    send(8'h55);
    send(8'h21);
    send(8'h22);
    @(negedge clk);
    rst_n   = 1'b0;
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    expect_out("midrst", 0, 0, 0, 0, 0, 0);
    check("midrst.wr_addr", 32'(wr_addr), 0);
    check("midrst.wr_data", 32'(wr_data), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    rx_done = 1'b0;
    send(8'h55);
    expect_out("midrst.55", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) px[i] = 8'($urandom);
    send_frame("after_rst", px, 1, 0, 2);

`ifdef UART_FRAME_CHECKSUM_EN
    px = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame("ck_bad", px, 1, 1, 0);
`endif

    check("done_err_exclusive", 32'(both_hi), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
